// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared encodings and helpers for the multi-channel PWM
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // A single channel still needs a one-bit select port.
    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - shared up / up-down counter with period boundary detection
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int PERIOD_RST = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] period,
    input  logic             center_mode,
    output logic [WIDTH-1:0] cnt,
    output logic             boundary
);

    dir_t             dir;
    dir_t             dir_nxt;
    logic             mode_act;
    logic             mode_nxt;
    logic [WIDTH-1:0] period_act;
    logic [WIDTH-1:0] period_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             bnd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            dir        <= DIR_UP;
            mode_act   <= MODE_EDGE;
            period_act <= WIDTH'(PERIOD_RST);
        end else begin
            cnt        <= cnt_nxt;
            dir        <= dir_nxt;
            mode_act   <= mode_nxt;
            period_act <= period_nxt;
        end
    end

    always_comb begin
        cnt_nxt    = cnt;
        dir_nxt    = dir;
        mode_nxt   = mode_act;
        period_nxt = period_act;
        bnd        = 1'b0;
        if (en) begin
            if (mode_act == MODE_EDGE) begin
                if (cnt >= period_act) begin
                    bnd     = 1'b1;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else if (period_act == '0) begin
                bnd     = 1'b1;
                cnt_nxt = '0;
                dir_nxt = DIR_UP;
            end else begin
                unique case (dir)
                    DIR_UP: begin
                        if (cnt >= period_act) begin
                            dir_nxt = DIR_DOWN;
                            cnt_nxt = cnt - 1'b1;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                    DIR_DOWN: begin
                        if (cnt == '0) begin
                            bnd     = 1'b1;
                            dir_nxt = DIR_UP;
                            cnt_nxt = WIDTH'(1);
                        end else begin
                            cnt_nxt = cnt - 1'b1;
                        end
                    end
                endcase
            end
            // A mode switch, or a zero center period, restarts the count cleanly at 0.
            if (bnd) begin
                period_nxt = period;
                mode_nxt   = center_mode;
                if ((center_mode != mode_act) ||
                    ((center_mode == MODE_CENTER) && (period == '0))) begin
                    cnt_nxt = '0;
                    dir_nxt = DIR_UP;
                end
            end
        end
    end

    assign boundary = bnd;

endmodule

// File: rtl/pwm_multich.sv
// rtl/pwm_multich.sv - multi-channel double-buffered PWM; optional PWM_POLARITY_EN adds per-channel output polarity
module pwm_multich
    import pwm_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int CHANNELS   = 4,
    parameter int PERIOD_RST = 1023,
    localparam int SEL_W     = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [WIDTH-1:0]    period,
    input  logic                center_mode,
    input  logic                duty_wr,
    input  logic [SEL_W-1:0]    duty_sel,
    input  logic [WIDTH-1:0]    duty_in,
`ifdef PWM_POLARITY_EN
    input  logic [CHANNELS-1:0] polarity,
`endif
    output logic [CHANNELS-1:0] pwm_out,
    output logic                cycle_start,
    output logic [WIDTH-1:0]    cnt
);

    logic                boundary;
    logic [CHANNELS-1:0] cmp;
    logic [CHANNELS-1:0] pol_act;

    pwm_timebase #(
        .WIDTH      (WIDTH),
        .PERIOD_RST (PERIOD_RST)
    ) u_timebase (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .period      (period),
        .center_mode (center_mode),
        .cnt         (cnt),
        .boundary    (boundary)
    );

`ifdef PWM_POLARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pol_act <= '0;
        end else if (boundary) begin
            pol_act <= polarity;
        end
    end
`else
    assign pol_act = '0;
`endif

    // Select values at or above CHANNELS match no channel, so such writes are dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             wr_hit;
        logic [WIDTH-1:0] duty_shadow;
        logic [WIDTH-1:0] duty_act;

        assign wr_hit = duty_wr && (duty_sel == SEL_W'(i));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                duty_shadow <= '0;
                duty_act    <= '0;
            end else begin
                if (wr_hit) begin
                    duty_shadow <= duty_in;
                end
                if (boundary) begin
                    duty_act <= wr_hit ? duty_in : duty_shadow;
                end
            end
        end

        assign cmp[i] = (cnt < duty_act);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out     <= '0;
            cycle_start <= 1'b0;
        end else begin
            cycle_start <= boundary;
            if (en) begin
                pwm_out <= cmp ^ pol_act;
            end
        end
    end

endmodule

// File: tb/tb_pwm_multich.sv
// tb/tb_pwm_multich.sv - directed and randomized checks of pwm_multich against a period-phase model
module tb_pwm_multich;

    localparam int W  = 10;
    localparam int CH = 6;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          center_mode;
    logic          duty_wr;
    logic [W-1:0]  period;
    logic [W-1:0]  duty_in;
    logic [W-1:0]  cnt;
    logic [SW-1:0] duty_sel;
    logic [CH-1:0] pwm_out;
    logic          cycle_start;
`ifdef PWM_POLARITY_EN
    logic [CH-1:0] polarity = '0;
`endif

    always #5 clk = ~clk;

    pwm_multich #(
        .WIDTH      (W),
        .CHANNELS   (CH),
        .PERIOD_RST (1023)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .period      (period),
        .center_mode (center_mode),
        .duty_wr     (duty_wr),
        .duty_sel    (duty_sel),
        .duty_in     (duty_in),
`ifdef PWM_POLARITY_EN
        .polarity    (polarity),
`endif
        .pwm_out     (pwm_out),
        .cycle_start (cycle_start),
        .cnt         (cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: m_t is the phase inside the current period; the count is derived from it.
    int            m_p;
    int            m_mode;
    int            m_t;
    int            m_shadow[CH];
    int            m_act[CH];
    logic [CH-1:0] m_pwm;
    logic          m_cs;

    function automatic int m_cnt();
        if (m_mode == 0 || m_t <= m_p) return m_t;
        return 2 * m_p - m_t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_p = 1023; m_mode = 0; m_t = 0; m_pwm = '0; m_cs = 1'b0;
        for (int i = 0; i < CH; i++) begin
            m_shadow[i] = 0;
            m_act[i]    = 0;
        end
    endtask

    task automatic tick();
        bit            bnd = 1'b0;
        int            nt  = m_t;
        int            c   = m_cnt();
        logic [CH-1:0] np  = m_pwm;
        if (en) begin
            if (m_mode == 0) begin
                if (m_t == m_p) begin bnd = 1'b1; nt = 0; end
                else nt = m_t + 1;
            end else if (m_p == 0 || m_t == 2 * m_p) begin
                bnd = 1'b1;
                nt  = (m_p == 0) ? 0 : 1;
            end else begin
                nt = m_t + 1;
            end
            for (int i = 0; i < CH; i++) np[i] = (c < m_act[i]);
        end
        if (duty_wr && int'(duty_sel) < CH) m_shadow[int'(duty_sel)] = int'(duty_in);
        if (bnd) begin
            if (int'(center_mode) != m_mode || (center_mode && period == '0)) nt = 0;
            m_p    = int'(period);
            m_mode = int'(center_mode);
            for (int i = 0; i < CH; i++) m_act[i] = m_shadow[i];
        end
        @(posedge clk);
        #1;
        m_t = nt; m_pwm = np; m_cs = bnd;
        chk("cnt", cnt, m_cnt());
        chk("pwm_out", pwm_out, m_pwm);
        chk("cycle_start", cycle_start, m_cs);
    endtask

    task automatic wr(input int sel, input int val);
        duty_wr = 1'b1; duty_sel = SW'(sel); duty_in = W'(val);
        tick();
        duty_wr = 1'b0;
    endtask

    // Skips to the next cycle_start, then counts highs of one channel until the following one.
    task automatic measure(input int ch, input int wr_at, input int wr_ch, input int wr_val,
                           output int highs, output int len);
        int guard = 0;
        highs = 0; len = 0;
        while (!cycle_start && guard < 5000) begin tick(); guard++; end
        do begin
            highs += int'(pwm_out[ch]);
            if (len == wr_at) begin
                len++;
                wr(wr_ch, wr_val);
            end else begin
                len++;
                tick();
            end
            guard++;
        end while (!cycle_start && guard < 5000);
        chk("measure_timeout", guard < 5000, 1);
    endtask

    int hi, ln, saved;
    int exp_c[8] = '{1, 2, 3, 4, 3, 2, 1, 0};
    int exp_p[8] = '{1, 1, 0, 0, 0, 0, 0, 1};

    initial begin
        reset = 1'b1; en = 1'b0; period = W'(999); center_mode = 1'b0;
        duty_wr = 1'b0; duty_sel = '0; duty_in = '0;
        model_reset();
        #12;
        chk("rst_cnt", cnt, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_cs", cycle_start, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        en    = 1'b1;

        // Edge mode, 725 of 1000
        wr(0, 725);
        measure(0, -1, 0, 0, hi, ln);
        chk("edge_high_725", hi, 725);
        chk("edge_len_1000", ln, 1000);

        // Mid-period rewrite only lands at the next period
        measure(0, 400, 0, 100, hi, ln);
        chk("midwr_cur_725", hi, 725);
        measure(0, -1, 0, 0, hi, ln);
        chk("midwr_next_100", hi, 100);
        chk("midwr_len", ln, 1000);

        // Duty extremes
        wr(1, 0);
        wr(2, 1023);
        measure(2, -1, 0, 0, hi, ln);
        measure(2, -1, 0, 0, hi, ln);
        chk("duty_max_high", hi, 1000);
        measure(1, -1, 0, 0, hi, ln);
        chk("duty_zero_high", hi, 0);

        // Out-of-range selects are ignored
        wr(7, 5);
        wr(6, 5);
        measure(0, -1, 0, 0, hi, ln);
        measure(0, -1, 0, 0, hi, ln);
        chk("badsel_ch0", hi, 100);
        chk("badsel_ch5", pwm_out[5], 0);

        // Write in the boundary cycle applies to the new period
        measure(3, 999, 3, 300, hi, ln);
        chk("bndwr_cur", hi, 0);
        measure(3, -1, 0, 0, hi, ln);
        chk("bndwr_next", hi, 300);

        // Center mode, period 4, duty 2
        period = W'(4); center_mode = 1'b1;
        wr(0, 2);
        measure(0, -1, 0, 0, hi, ln);
        for (int k = 0; k < 8; k++) begin
            chk("center_cnt", cnt, exp_c[k]);
            chk("center_pwm", pwm_out[0], exp_p[k]);
            tick();
        end
        chk("center_wrap_cs", cycle_start, 1);

        // Enable freeze
        period = W'(999); center_mode = 1'b0;
        measure(0, -1, 0, 0, hi, ln);
        repeat (400) tick();
        saved = int'(cnt);
        en = 1'b0;
        repeat (20) tick();
        chk("freeze_cnt", cnt, saved);
        en = 1'b1;
        tick();
        chk("resume_cnt", cnt, saved + 1);

        // Asynchronous reset mid-period
        repeat (20) tick();
        chk("pre_rst_ch2", pwm_out[2], 1);
        reset = 1'b1;
        #1;
        chk("async_rst_pwm", pwm_out, 0);
        chk("async_rst_cnt", cnt, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (1023) tick();
        chk("rst_period_top", cnt, 1023);
        tick();
        chk("rst_period_wrap", cnt, 0);
        chk("rst_period_cs", cycle_start, 1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            en       = ($urandom_range(0, 9) != 0);
            duty_wr  = ($urandom_range(0, 2) == 0);
            duty_sel = SW'($urandom_range(0, 7));
            duty_in  = W'($urandom_range(0, 40));
            if ($urandom_range(0, 49) == 0) begin
                period      = W'($urandom_range(0, 30));
                center_mode = 1'($urandom_range(0, 1));
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
